logic_gates: RTL and testbench

Registered bank of bitwise logic operators on two WIDTH-bit operands. Each cycle it produces the buffer, NOT, AND, NAND, OR, NOR, XOR and XNOR of the operands. All eight results are registered on one clock with synchronous active-high reset. It serves as a basic gate-level datapath primitive and as the reference block for gate-function vector regression.

---
 rtl/logic_gates.sv | 69 ++++++
 tb/tb_logic_gates.sv | 135 +++++++++++++
 2 files changed

// File: rtl/logic_gates.sv
// Registered bank of the eight two-input bitwise gate functions on WIDTH-bit operands.
// One-cycle latency; results hold between accepted operand pairs.
module logic_gates #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] ynot,
    output logic [WIDTH-1:0] yand,
    output logic [WIDTH-1:0] ynand,
    output logic [WIDTH-1:0] yor,
    output logic [WIDTH-1:0] ynor,
    output logic [WIDTH-1:0] yxor,
    output logic [WIDTH-1:0] ynxor
);

    logic             vld_p1;
    logic [WIDTH-1:0] y_p1;
    logic [WIDTH-1:0] ynot_p1;
    logic [WIDTH-1:0] yand_p1;
    logic [WIDTH-1:0] ynand_p1;
    logic [WIDTH-1:0] yor_p1;
    logic [WIDTH-1:0] ynor_p1;
    logic [WIDTH-1:0] yxor_p1;
    logic [WIDTH-1:0] ynxor_p1;

    // Stage p0 -> p1: the inverted results also clear to zero on reset, not to all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1   <= 1'b0;
            y_p1     <= '0;
            ynot_p1  <= '0;
            yand_p1  <= '0;
            ynand_p1 <= '0;
            yor_p1   <= '0;
            ynor_p1  <= '0;
            yxor_p1  <= '0;
            ynxor_p1 <= '0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                y_p1     <= a;
                ynot_p1  <= ~a;
                yand_p1  <= a & b;
                ynand_p1 <= ~(a & b);
                yor_p1   <= a | b;
                ynor_p1  <= ~(a | b);
                yxor_p1  <= a ^ b;
                ynxor_p1 <= ~(a ^ b);
            end
        end
    end

    assign out_valid = vld_p1;
    assign y         = y_p1;
    assign ynot      = ynot_p1;
    assign yand      = yand_p1;
    assign ynand     = ynand_p1;
    assign yor       = yor_p1;
    assign ynor      = ynor_p1;
    assign yxor      = yxor_p1;
    assign ynxor     = ynxor_p1;

endmodule

// File: tb/tb_logic_gates.sv
// Bench for logic_gates: directed steps, exhaustive sweep and random traffic
// checked against a per-bit arithmetic truth model.
module tb_logic_gates;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic [W-1:0] y, ynot, yand, ynand, yor, ynor, yxor, ynxor;

    int checks_total  = 0;
    int checks_passed = 0;

    logic         exp_valid;
    logic [W-1:0] exp_res [8];
    string        names [8] = '{"y", "ynot", "yand", "ynand", "yor", "ynor", "yxor", "ynxor"};

    logic_gates #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .a(a), .b(b),
        .out_valid(out_valid), .y(y), .ynot(ynot), .yand(yand), .ynand(ynand),
        .yor(yor), .ynor(ynor), .yxor(yxor), .ynxor(ynxor)
    );

    always #5 clk = ~clk;

    // Truth of each gate computed per bit with integer arithmetic on 0/1 values.
    function automatic logic [W-1:0] gate(input int op, input logic [W-1:0] p, input logic [W-1:0] q);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            int ai, bi, v;
            ai = p[i] ? 1 : 0;
            bi = q[i] ? 1 : 0;
            case (op)
                0: v = ai;
                1: v = 1 - ai;
                2: v = ai * bi;
                3: v = 1 - ai * bi;
                4: v = ai + bi - ai * bi;
                5: v = 1 - (ai + bi - ai * bi);
                6: v = (ai + bi) % 2;
                default: v = 1 - (ai + bi) % 2;
            endcase
            r[i] = (v == 1);
        end
        return r;
    endfunction

    task automatic check1(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks_total++;
        assert (obs === expv) checks_passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    endtask

    task automatic check_all(input string tag);
        logic [W-1:0] obs [8];
        obs = '{y, ynot, yand, ynand, yor, ynor, yxor, ynxor};
        checks_total++;
        assert (out_valid === exp_valid) checks_passed++;
        else $error("FAIL %s.out_valid: observed %b expected %b", tag, out_valid, exp_valid);
        for (int k = 0; k < 8; k++) check1({tag, ".", names[k]}, obs[k], exp_res[k]);
    endtask

    // Drive one cycle, advance the model at the edge, then sample 1 time unit later.
    task automatic step(input string tag, input logic r, input logic v,
                        input logic [W-1:0] aa, input logic [W-1:0] bb);
        reset = r; in_valid = v; a = aa; b = bb;
        @(posedge clk);
        if (r) begin
            exp_valid = 1'b0;
            for (int k = 0; k < 8; k++) exp_res[k] = '0;
        end else begin
            exp_valid = v;
            if (v) for (int k = 0; k < 8; k++) exp_res[k] = gate(k, aa, bb);
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; a = '0; b = '0;
        exp_valid = 1'b0;
        for (int k = 0; k < 8; k++) exp_res[k] = '0;

        step("reset0", 1'b1, 1'b1, 4'hF, 4'hF);
        step("reset1", 1'b1, 1'b1, 4'hF, 4'hF);

        step("mixed", 1'b0, 1'b1, 4'b0101, 4'b0011);
        check1("mixed.yand_const", yand, 4'b0001);
        check1("mixed.ynor_const", ynor, 4'b1000);
        check1("mixed.ynxor_const", ynxor, 4'b1001);

        step("zeros", 1'b0, 1'b1, 4'b0000, 4'b0000);
        check1("zeros.ynand_const", ynand, 4'b1111);
        step("ones", 1'b0, 1'b1, 4'b1111, 4'b1111);
        check1("ones.ynxor_const", ynxor, 4'b1111);
        check1("ones.ynot_const", ynot, 4'b0000);

        step("hold_load", 1'b0, 1'b1, 4'b1100, 4'b1010);
        for (int i = 0; i < 3; i++) begin
            step("hold_idle", 1'b0, 1'b0, 4'b0011, 4'b0101);
            check1("hold.yand_const", yand, 4'b1000);
            check1("hold.yor_const", yor, 4'b1110);
            check1("hold.yxor_const", yxor, 4'b0110);
        end

        step("pre_mid", 1'b0, 1'b1, 4'b0111, 4'b0001);
        step("reset_mid", 1'b1, 1'b1, 4'b1001, 4'b0110);
        step("post_reset_idle", 1'b0, 1'b0, 4'b1001, 4'b0110);
        step("post_reset_first", 1'b0, 1'b1, 4'b1010, 4'b0110);

        for (int i = 0; i < 256; i++) begin
            logic [7:0] ab;
            ab = i[7:0];
            step("sweep", 1'b0, 1'b1, ab[7:4], ab[3:0]);
            check1("sweep.nand_pair", ynand, ~yand);
            check1("sweep.nor_pair", ynor, ~yor);
            check1("sweep.nxor_pair", ynxor, ~yxor);
            check1("sweep.not_pair", ynot, ~y);
        end

        for (int i = 0; i < 300; i++) begin
            step("random", ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                 W'($urandom), W'($urandom));
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
